// File: rtl/sram_responder.sv
// Memory-side responder for the active-low SRAM strobe bus: register-based storage
// with programmable read/write wait states, byte lanes and a sticky range-error flag.
module sram_responder #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_W    = 8,
  parameter int unsigned READ_WAIT  = 1,
  parameter int unsigned WRITE_WAIT = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              CE_N,
  input  logic              OE_N,
  input  logic              WE_N,
  input  logic              UB_N,
  input  logic              LB_N,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] Data_in,
  output logic [DATA_W-1:0] Data_out,
  output logic              Data_oe,
  output logic              Ready,
  output logic              Err,
  input  logic              Err_clr
);

  localparam int unsigned DEPTH = 1 << DEPTH_W;
  localparam int unsigned LANE  = DATA_W / 2;
  localparam logic [2:0] RD_RELOAD = 3'((READ_WAIT  > 1) ? READ_WAIT  - 2 : 0);
  localparam logic [2:0] WR_RELOAD = 3'((WRITE_WAIT > 1) ? WRITE_WAIT - 2 : 0);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_DRIVE = 3'd2,
    WR_WAIT  = 3'd3,
    WR_DONE  = 3'd4
  } state_t;

  state_t              state;
  logic [2:0]          cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                rd_c;
  logic                wr_c;
  logic                oor_c;
  logic                addr_chg_c;
  logic [DEPTH_W-1:0]  idx_c;
  logic [DATA_W-1:0]   rd_data_c;
  logic                start_wr_c;
  logic                commit_c;
  logic                load_c;
  logic [ADDR_W-1:0]   cm_addr_c;
  logic                cm_oor_c;
  logic [DEPTH_W-1:0]  cm_idx_c;
  logic [DATA_W-1:0]   wr_word_c;

  // Bus decode and the read/commit datapath
  always_comb begin
    rd_c       = !CE_N && !OE_N && WE_N;
    wr_c       = !CE_N && !WE_N;
    idx_c      = ADDR[DEPTH_W-1:0];
    oor_c      = |ADDR[ADDR_W-1:DEPTH_W];
    addr_chg_c = (ADDR != addr_q);

    rd_data_c = '0;
    if (!oor_c) begin
      if (!UB_N) rd_data_c[DATA_W-1:LANE] = mem[idx_c][DATA_W-1:LANE];
      if (!LB_N) rd_data_c[LANE-1:0]      = mem[idx_c][LANE-1:0];
    end

    // A write may interrupt a read in progress and starts exactly as from IDLE
    start_wr_c = wr_c && ((state == IDLE) || (state == RD_WAIT) || (state == RD_DRIVE));
    commit_c   = (start_wr_c && (WRITE_WAIT == 1)) ||
                 (wr_c && (state == WR_WAIT) && (cnt == 3'd0));
    load_c     = rd_c && (((state == IDLE) && (READ_WAIT == 1)) ||
                          ((state == RD_WAIT) && !addr_chg_c && (cnt == 3'd0)));

    cm_addr_c = start_wr_c ? ADDR : addr_q;
    cm_oor_c  = |cm_addr_c[ADDR_W-1:DEPTH_W];
    cm_idx_c  = cm_addr_c[DEPTH_W-1:0];
    wr_word_c = mem[cm_idx_c];
    if (!UB_N) wr_word_c[DATA_W-1:LANE] = Data_in[DATA_W-1:LANE];
    if (!LB_N) wr_word_c[LANE-1:0]      = Data_in[LANE-1:0];
  end

  // Access FSM, storage and registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      Data_out <= '0;
      Data_oe  <= 1'b0;
      Ready    <= 1'b0;
      Err      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      Data_oe <= 1'b0;
      Ready   <= 1'b0;

      if (commit_c && !cm_oor_c) mem[cm_idx_c] <= wr_word_c;
      if (load_c) Data_out <= rd_data_c;

      if ((commit_c && cm_oor_c) || (load_c && oor_c)) Err <= 1'b1;
      else if (Err_clr)                                 Err <= 1'b0;

      if (start_wr_c) begin
        addr_q <= ADDR;
        if (WRITE_WAIT == 1) begin
          state <= WR_DONE;
          Ready <= 1'b1;
        end else begin
          state <= WR_WAIT;
          cnt   <= WR_RELOAD;
        end
      end else begin
        case (state)
          IDLE: begin
            if (rd_c) begin
              addr_q <= ADDR;
              if (READ_WAIT == 1) begin
                state   <= RD_DRIVE;
                Data_oe <= 1'b1;
                Ready   <= 1'b1;
              end else begin
                state <= RD_WAIT;
                cnt   <= RD_RELOAD;
              end
            end
          end
          RD_WAIT: begin
            if (!rd_c) begin
              state <= IDLE;
            end else if (addr_chg_c) begin
              addr_q <= ADDR;
              cnt    <= RD_RELOAD;
            end else if (cnt == 3'd0) begin
              state   <= RD_DRIVE;
              Data_oe <= 1'b1;
              Ready   <= 1'b1;
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
          RD_DRIVE: begin
            // Address change drops the handshake for a cycle, then relaunches from IDLE
            if (!rd_c || addr_chg_c) begin
              state <= IDLE;
            end else begin
              Data_oe <= 1'b1;
              Ready   <= 1'b1;
            end
          end
          WR_WAIT: begin
            if (!wr_c) begin
              state <= IDLE;
            end else if (cnt == 3'd0) begin
              state <= WR_DONE;
              Ready <= 1'b1;
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
          WR_DONE: begin
            if (!wr_c) state <= IDLE;
            else       Ready <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: a default instance and a slow (read 3 / write 4) instance
// share one bus and are checked every cycle against a transaction-level model.
module tb_sram_responder;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        CE_N = 1'b1;
  logic        OE_N = 1'b1;
  logic        WE_N = 1'b1;
  logic        UB_N = 1'b1;
  logic        LB_N = 1'b1;
  logic [19:0] ADDR = '0;
  logic [15:0] Data_in = '0;
  logic        Err_clr = 1'b0;

  logic [15:0] dout [2];
  logic        doe  [2];
  logic        rdy  [2];
  logic        err  [2];

  always #5 Clk = ~Clk;

  sram_responder u_dflt (
    .Clk(Clk), .Reset_n(Reset_n), .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N),
    .UB_N(UB_N), .LB_N(LB_N), .ADDR(ADDR), .Data_in(Data_in),
    .Data_out(dout[0]), .Data_oe(doe[0]), .Ready(rdy[0]), .Err(err[0]),
    .Err_clr(Err_clr)
  );

  sram_responder #(.READ_WAIT(3), .WRITE_WAIT(4)) u_slow (
    .Clk(Clk), .Reset_n(Reset_n), .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N),
    .UB_N(UB_N), .LB_N(LB_N), .ADDR(ADDR), .Data_in(Data_in),
    .Data_out(dout[1]), .Data_oe(doe[1]), .Ready(rdy[1]), .Err(err[1]),
    .Err_clr(Err_clr)
  );

  // Reference model: per instance latency, word storage, last read word, sticky error
  int          rw_lat [2] = '{1, 3};
  int          ww_lat [2] = '{1, 4};
  logic [15:0] m_mem  [2][256];
  logic [15:0] m_dout [2];
  logic        m_err  [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit out_of_range(input logic [19:0] a);
    return a[19:8] != 12'h000;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) m_mem[d][i] = '0;
      m_dout[d] = '0;
      m_err[d]  = 1'b0;
    end
  endtask

  task automatic model_commit(input int d, input logic [19:0] a, input logic [15:0] wd,
                              input bit ub_n, input bit lb_n);
    logic [7:0] i;
    i = a[7:0];
    if (out_of_range(a)) m_err[d] = 1'b1;
    else begin
      if (!ub_n) m_mem[d][i][15:8] = wd[15:8];
      if (!lb_n) m_mem[d][i][7:0]  = wd[7:0];
    end
  endtask

  task automatic model_load(input int d, input logic [19:0] a, input bit ub_n, input bit lb_n);
    logic [7:0] i;
    i = a[7:0];
    if (out_of_range(a)) begin
      m_dout[d] = 16'h0000;
      m_err[d]  = 1'b1;
    end else begin
      m_dout[d] = {ub_n ? 8'h00 : m_mem[d][i][15:8], lb_n ? 8'h00 : m_mem[d][i][7:0]};
    end
  endtask

  task automatic check_outs(input string name, input int k, input bit is_wr, input bit active);
    bit exp_oe, exp_rdy;
    for (int d = 0; d < 2; d++) begin
      exp_oe  = active && !is_wr && (k >= rw_lat[d]);
      exp_rdy = active && (is_wr ? (k >= ww_lat[d]) : (k >= rw_lat[d]));
      check($sformatf("%s.d%0d.k%0d.oe",   name, d, k), 32'(doe[d]),  32'(exp_oe));
      check($sformatf("%s.d%0d.k%0d.rdy",  name, d, k), 32'(rdy[d]),  32'(exp_rdy));
      check($sformatf("%s.d%0d.k%0d.err",  name, d, k), 32'(err[d]),  32'(m_err[d]));
      check($sformatf("%s.d%0d.k%0d.data", name, d, k), 32'(dout[d]), 32'(m_dout[d]));
    end
  endtask

  // One bus access held for `hold` cycles, then released (or cut short by reset)
  task automatic txn(input string name, input bit is_wr, input bit oe_too,
                     input logic [19:0] a, input logic [15:0] wd,
                     input bit ub_n, input bit lb_n, input int hold, input bit rst_end);
    CE_N = 1'b0;
    WE_N = !is_wr;
    OE_N = is_wr && !oe_too;
    ADDR = a;
    Data_in = wd;
    UB_N = ub_n;
    LB_N = lb_n;
    for (int k = 1; k <= hold; k++) begin
      @(posedge Clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (is_wr && k == ww_lat[d])  model_commit(d, a, wd, ub_n, lb_n);
        if (!is_wr && k == rw_lat[d]) model_load(d, a, ub_n, lb_n);
      end
      check_outs(name, k, is_wr, 1'b1);
    end
    CE_N = 1'b1;
    OE_N = 1'b1;
    WE_N = 1'b1;
    if (rst_end) begin
      Reset_n = 1'b0;
      #1;
      model_clear();
      check_outs({name, ".rst"}, 0, is_wr, 1'b0);
      @(posedge Clk); #1;
      Reset_n = 1'b1;
    end else begin
      @(posedge Clk); #1;
      check_outs({name, ".rel"}, 0, is_wr, 1'b0);
    end
  endtask

  task automatic pulse_err_clr();
    Err_clr = 1'b1;
    @(posedge Clk); #1;
    Err_clr = 1'b0;
    for (int d = 0; d < 2; d++) m_err[d] = 1'b0;
    check_outs("errclr", 0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [19:0] a;
    bit          w;
    model_clear();
    @(posedge Clk); #1;
    check_outs("reset", 0, 1'b0, 1'b0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    txn("wr1234",   1'b1, 1'b0, 20'h00010, 16'h1234, 1'b0, 1'b0, 4, 1'b0);
    txn("rd1234",   1'b0, 1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0, 4, 1'b0);
    txn("rd2cyc",   1'b0, 1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0, 2, 1'b0);
    txn("wrlb",     1'b1, 1'b0, 20'h00010, 16'hABCD, 1'b1, 1'b0, 4, 1'b0);
    txn("rdboth",   1'b0, 1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0, 4, 1'b0);
    txn("rdub",     1'b0, 1'b0, 20'h00010, 16'h0000, 1'b0, 1'b1, 4, 1'b0);
    txn("rdoor",    1'b0, 1'b0, 20'h00100, 16'h0000, 1'b0, 1'b0, 4, 1'b0);
    pulse_err_clr();
    txn("wroor",    1'b1, 1'b0, 20'h00100, 16'hFFFF, 1'b0, 1'b0, 4, 1'b0);
    txn("rdzero",   1'b0, 1'b0, 20'h00000, 16'h0000, 1'b0, 1'b0, 4, 1'b0);
    pulse_err_clr();
    txn("rdabort",  1'b0, 1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0, 2, 1'b0);
    txn("wrweoe",   1'b1, 1'b1, 20'h00020, 16'h5555, 1'b0, 1'b0, 4, 1'b0);
    txn("rd5555",   1'b0, 1'b0, 20'h00020, 16'h0000, 1'b0, 1'b0, 4, 1'b0);
    txn("wrnolane", 1'b1, 1'b0, 20'h00020, 16'h0F0F, 1'b1, 1'b1, 4, 1'b0);
    txn("rdnolane", 1'b0, 1'b0, 20'h00020, 16'h0000, 1'b0, 1'b0, 4, 1'b0);
    txn("wrrst",    1'b1, 1'b0, 20'h00030, 16'hBEEF, 1'b0, 1'b0, 2, 1'b1);
    txn("rdafrst",  1'b0, 1'b0, 20'h00030, 16'h0000, 1'b0, 1'b0, 4, 1'b0);
    txn("rd1234z",  1'b0, 1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0, 4, 1'b0);

    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 9) == 0) a = {12'($urandom_range(1, 4095)), 8'($urandom_range(0, 255))};
      else                           a = 20'($urandom_range(0, 15));
      w = 1'($urandom_range(0, 1));
      txn($sformatf("rnd%0d", n), w, 1'($urandom_range(0, 1)), a, 16'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 5), 1'b0);
      if ($urandom_range(0, 7) == 0) pulse_err_clr();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
